// File: rtl/register_file_sb.sv
// register_file_sb: register file for the multicycle CPU datapath.
// It has two combinational read ports, one synchronous write port and an
// optional write-to-read bypass. A pending bit per register records the
// destination of each in-flight instruction, so control can stall on
// RAW and WAW hazards.
module register_file_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = $clog2(NREG),
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_add,
    input  logic [AW-1:0]   rs2_add,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [AW-1:0]   rd_add,
    input  logic [XLEN-1:0] wr_data,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    output logic            busy1,
    output logic            busy2,
    output logic [AW:0]     pending_cnt
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;
    logic [AW:0]     cnt_q;
    logic [AW:0]     cnt_d;

    logic wr_en;        // write that actually lands in storage
    logic issue_zero;   // issue aimed at the hardwired zero register
    logic issue_acc;    // accepted issue that marks a real register
    logic set_new;      // pending bit goes 0 -> 1 this edge
    logic clr_hit;      // pending bit goes 1 -> 0 this edge

    assign wr_en      = we && !(ZERO_REG && (rd_add == '0));
    assign issue_zero = ZERO_REG && (issue_rd == '0);

    // Issue is allowed when the slot is free or is being freed by this cycle's write
    always_comb begin
        issue_ready = 1'b1;
        if (!rst && !issue_zero)
            issue_ready = !pending_q[issue_rd] || (we && (rd_add == issue_rd));
    end

    // Next pending vector: the write clears first, then an accepted issue sets (set wins)
    always_comb begin
        pending_d = pending_q;
        issue_acc = issue_valid && issue_ready && !issue_zero;
        set_new   = issue_acc && !pending_q[issue_rd];
        clr_hit   = we && pending_q[rd_add] && !(issue_acc && (issue_rd == rd_add));
        if (we)
            pending_d[rd_add] = 1'b0;
        if (issue_acc)
            pending_d[issue_rd] = 1'b1;
        if (ZERO_REG)
            pending_d[0] = 1'b0;
        cnt_d = cnt_q + {{AW{1'b0}}, set_new} - {{AW{1'b0}}, clr_hit};
    end

    // Data storage: one register per entry, each with its own write decode
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    regs_q[gi] <= '0;
                else if (wr_en && (rd_add == AW'(gi)))
                    regs_q[gi] <= wr_data;
            end
        end
    endgenerate

    // Pending bits and their population count update on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pending_cnt = cnt_q;

    // Read port 1: zero register, then bypass, then storage
    always_comb begin
        rd1   = '0;
        busy1 = 1'b0;
        if (!rst && !(ZERO_REG && (rs1_add == '0))) begin
            if (BYPASS && we && (rd_add == rs1_add)) begin
                rd1 = wr_data;
            end else begin
                rd1   = regs_q[rs1_add];
                busy1 = pending_q[rs1_add];
            end
        end
    end

    // Read port 2: same priority as port 1
    always_comb begin
        rd2   = '0;
        busy2 = 1'b0;
        if (!rst && !(ZERO_REG && (rs2_add == '0))) begin
            if (BYPASS && we && (rd_add == rs2_add)) begin
                rd2 = wr_data;
            end else begin
                rd2   = regs_q[rs2_add];
                busy2 = pending_q[rs2_add];
            end
        end
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb with default parameters
// (XLEN=32, NREG=32, ZERO_REG=1, BYPASS=1).
module tb_register_file_sb;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_add;
    logic [4:0]  rs2_add;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        we;
    logic [4:0]  rd_add;
    logic [31:0] wr_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        busy1;
    logic        busy2;
    logic [5:0]  pending_cnt;

    int n_checks = 0;
    int n_errors = 0;

    register_file_sb dut (
        .clk         (clk),
        .rst         (rst),
        .rs1_add     (rs1_add),
        .rs2_add     (rs2_add),
        .rd1         (rd1),
        .rd2         (rd2),
        .we          (we),
        .rd_add      (rd_add),
        .wr_data     (wr_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .busy1       (busy1),
        .busy2       (busy2),
        .pending_cnt (pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; rd_add = '0; wr_data = '0;
        rs1_add = '0; rs2_add = '0; issue_valid = 1'b0; issue_rd = '0;
        #2 rst = 1'b1;
        // Outputs during reset, even with a write pending on the bus
        we = 1'b1; rd_add = 5'd5; wr_data = 32'hFF; rs1_add = 5'd5; issue_rd = 5'd5;
        #1;
        chk("rst_rd1", rd1, 32'h0);
        chk("rst_cnt", {26'd0, pending_cnt}, 32'd0);
        chk("rst_ready", {31'd0, issue_ready}, 32'd1);
        we = 1'b0;
        tick();
        #2 rst = 1'b0;
        #1;
        // Every register reads 0 and idle after reset
        for (int i = 0; i < 32; i++) begin
            rs1_add = 5'(i); rs2_add = 5'(31 - i); issue_rd = 5'(i);
            #1;
            chk("init_rd1", rd1, 32'h0);
            chk("init_rd2", rd2, 32'h0);
            chk("init_busy", {30'd0, busy1, busy2}, 32'd0);
            chk("init_ready", {31'd0, issue_ready}, 32'd1);
        end
        chk("init_cnt", {26'd0, pending_cnt}, 32'd0);

        // Write r5 with bypass visible in the same cycle
        tick();
        we = 1'b1; rd_add = 5'd5; wr_data = 32'hDEADBEEF; rs1_add = 5'd5;
        #1 chk("byp_r5", rd1, 32'hDEADBEEF);
        tick();
        we = 1'b0;
        #1 chk("store_r5", rd1, 32'hDEADBEEF);

        // r0 is hardwired: write and issue are both ignored
        we = 1'b1; rd_add = 5'd0; wr_data = 32'h12345678; rs1_add = 5'd0;
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1;
        chk("r0_byp", rd1, 32'h0);
        chk("r0_ready", {31'd0, issue_ready}, 32'd1);
        tick();
        we = 1'b0; issue_valid = 1'b0;
        #1;
        chk("r0_rd", rd1, 32'h0);
        chk("r0_busy", {31'd0, busy1}, 32'd0);
        chk("r0_cnt", {26'd0, pending_cnt}, 32'd0);

        // Issue r7, then observe the hazard and its release by a write
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0; rs1_add = 5'd7;
        #1;
        chk("r7_busy", {31'd0, busy1}, 32'd1);
        chk("r7_cnt", {26'd0, pending_cnt}, 32'd1);
        chk("r7_notready", {31'd0, issue_ready}, 32'd0);
        we = 1'b1; rd_add = 5'd7; wr_data = 32'hA5;
        #1;
        chk("r7_busy_byp", {31'd0, busy1}, 32'd0);
        chk("r7_rd_byp", rd1, 32'hA5);
        chk("r7_ready_wr", {31'd0, issue_ready}, 32'd1);
        tick();
        we = 1'b0;
        #1;
        chk("r7_cnt_clr", {26'd0, pending_cnt}, 32'd0);
        chk("r7_busy_clr", {31'd0, busy1}, 32'd0);
        chk("r7_rd", rd1, 32'hA5);

        // r9 pending; same-cycle write and issue of r9: set wins
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        chk("r9_cnt", {26'd0, pending_cnt}, 32'd1);
        we = 1'b1; rd_add = 5'd9; wr_data = 32'h1;
        #1 chk("r9_ready", {31'd0, issue_ready}, 32'd1);
        tick();
        we = 1'b0; issue_valid = 1'b0; rs1_add = 5'd9;
        #1;
        chk("r9_rd", rd1, 32'h1);
        chk("r9_busy", {31'd0, busy1}, 32'd1);
        chk("r9_cnt_keep", {26'd0, pending_cnt}, 32'd1);

        // Write r9 while issuing r10: both take effect
        we = 1'b1; rd_add = 5'd9; wr_data = 32'h99; issue_valid = 1'b1; issue_rd = 5'd10;
        #1 chk("r10_ready", {31'd0, issue_ready}, 32'd1);
        tick();
        we = 1'b0; issue_valid = 1'b0; rs2_add = 5'd10;
        #1;
        chk("r9_busy_clr", {31'd0, busy1}, 32'd0);
        chk("r9_rd2", rd1, 32'h99);
        chk("r10_busy", {31'd0, busy2}, 32'd1);
        chk("swap_cnt", {26'd0, pending_cnt}, 32'd1);

        // Rejected issue of r10 changes nothing
        issue_valid = 1'b1; issue_rd = 5'd10;
        #1 chk("r10_reject", {31'd0, issue_ready}, 32'd0);
        tick();
        issue_valid = 1'b0;
        #1 chk("reject_cnt", {26'd0, pending_cnt}, 32'd1);

        // Store r3, then issue r1..r15 and reset mid-cycle
        we = 1'b1; rd_add = 5'd3; wr_data = 32'h33;
        tick();
        we = 1'b0; rs2_add = 5'd3;
        #1 chk("r3_rd", rd2, 32'h33);
        for (int i = 1; i <= 15; i++) begin
            issue_valid = 1'b1; issue_rd = 5'(i);
            tick();
        end
        issue_valid = 1'b0; rs1_add = 5'd10;
        #1;
        chk("seq_cnt", {26'd0, pending_cnt}, 32'd15);
        chk("seq_busy", {30'd0, busy1, busy2}, 32'd3);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_cnt", {26'd0, pending_cnt}, 32'd0);
        chk("mid_rst_busy", {30'd0, busy1, busy2}, 32'd0);
        #1 rst = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            rs1_add = 5'(i); rs2_add = 5'(i); issue_rd = 5'(i);
            #1;
            chk("post_rd1", rd1, 32'h0);
            chk("post_busy", {30'd0, busy1, busy2}, 32'd0);
            chk("post_ready", {31'd0, issue_ready}, 32'd1);
        end
        chk("post_cnt", {26'd0, pending_cnt}, 32'd0);

        // First edge after reset behaves normally
        issue_valid = 1'b1; issue_rd = 5'd4;
        tick();
        issue_valid = 1'b0; rs1_add = 5'd4;
        #1;
        chk("after_cnt", {26'd0, pending_cnt}, 32'd1);
        chk("after_busy", {31'd0, busy1}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "timeout");
    end

endmodule
